// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin bus multiplexer.
package rr_mux_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Index width for n items; never returns less than 1 so a 2-entry mux still gets a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_bus_mux_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr, wrapping N_CH-1 -> 0.
module rr_arbiter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int c;

  // Starting at k=1 puts the last winner at the lowest priority; k=N_CH revisits it.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    c          = 0;
    for (int k = 1; k <= N_CH; k++) begin
      c = int'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!gnt_any && req[SEL_W'(c)]) begin
        gnt_any                 = 1'b1;
        gnt_idx                 = SEL_W'(c);
        gnt_onehot[SEL_W'(c)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_mux.sv
// N-channel registered bus mux with round-robin arbitration and valid/ready handshake.
// Define RR_LOCK_EN to hold the grant on one channel until its in_last beat (burst lock).
module rr_bus_mux
  import rr_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

`ifdef RR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_ch;
  logic [N_CH-1:0]  lock_mask;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;

  // Request masking: in LOCK only the stored channel may compete.
  always_comb begin
    lock_mask          = '0;
    lock_mask[lock_ch] = 1'b1;
    req                = (state == ST_LOCK) ? (in_valid & lock_mask) : in_valid;
  end

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req        (req),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  assign load     = !reset && enable && gnt_any && (!out_valid || out_ready);
  assign in_ready = load ? gnt_onehot : '0;

  // Output register stage: a load and a pop on the same edge swap beats without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
      state     <= ST_ARB;
      lock_ch   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_sel   <= gnt_idx;
      rr_ptr    <= gnt_idx;
      lock_ch   <= gnt_idx;
      state     <= (LOCK_EN && !in_last[gnt_idx]) ? ST_LOCK : ST_ARB;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_bus_mux.sv
// Randomised and directed bench for rr_bus_mux against a behavioural round-robin model.
module tb_rr_bus_mux;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what the output register and arbiter should hold.
  int          m_ptr  = N - 1;
  bit          m_lock = 1'b0;
  int          m_lch  = 0;
  bit          m_ov   = 1'b0;
  logic [W-1:0] m_od  = '0;
  int          m_os   = 0;

  always #5 clk = ~clk;

  rr_bus_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; checks in_ready before the edge and the output register after it.
  task automatic step(input bit rst, input bit en, input logic [N-1:0] vld,
                      input logic [N-1:0] last, input bit ordy);
    bit           ld;
    int           g;
    logic [N-1:0] rq;
    reset     = rst;
    enable    = en;
    in_valid  = vld;
    in_last   = last;
    out_ready = ordy;
    #1;
    rq = vld;
    if (m_lock) rq = vld & (N'(1) << m_lch);
    ld = !rst && en && (rq != 0) && (!m_ov || ordy);
    g  = 0;
    if (ld) begin
      for (int k = 1; k <= N; k++) begin
        if (rq[(m_ptr + k) % N]) begin
          g = (m_ptr + k) % N;
          break;
        end
      end
    end
    chk("in_ready", 32'(in_ready), ld ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    if (rst) begin
      m_ov = 1'b0; m_od = '0; m_os = 0; m_ptr = N - 1; m_lock = 1'b0;
    end else if (ld) begin
      m_ov  = 1'b1;
      m_od  = in_data[g*W +: W];
      m_os  = g;
      m_ptr = g;
`ifdef RR_LOCK_EN
      m_lock = !last[g];
      m_lch  = g;
`endif
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("out_sel", 32'(out_sel), 32'(m_os));
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'hA000 + 16'(i);
  endtask

  int lock_exp[4];

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    set_ramp();
    repeat (2) @(posedge clk);
    #1;

    // Reset with every channel requesting
    repeat (2) step(1, 1, 8'hFF, 8'h00, 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);

    // Fair rotation with all channels valid
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 8'hFF, 8'h00, 1);
      chk("rr_sel", 32'(out_sel), 32'(i % N));
      chk("rr_data", 32'(out_data), 32'h0000A000 + 32'(i % N));
    end

    // Backpressure holds beat 0, then release loads channel 1 on the pop edge
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hFF, 8'h00, 0);
      chk("bp_hold", 32'(out_data), 32'h0000A000);
    end
    step(0, 1, 8'hFF, 8'h00, 1);
    chk("bp_release_sel", 32'(out_sel), 32'd1);

    // Sparse requesters with wrap from pointer 6
    step(1, 0, 8'h00, 8'h00, 1);
    step(0, 1, 8'h40, 8'h00, 1);
    chk("wrap_setup", 32'(out_sel), 32'd6);
    step(0, 1, 8'h42, 8'h00, 1);
    chk("wrap_g1", 32'(out_sel), 32'd1);
    step(0, 1, 8'h42, 8'h00, 1);
    chk("wrap_g6", 32'(out_sel), 32'd6);
    step(0, 1, 8'h42, 8'h00, 1);
    chk("wrap_g1b", 32'(out_sel), 32'd1);
    step(0, 0, 8'h42, 8'h00, 1);
    chk("enable_drain", 32'(out_valid), 32'd0);

    // Burst lock: ch2 sends three beats (last on the third) while ch3 waits
`ifdef RR_LOCK_EN
    lock_exp = '{2, 2, 2, 3};
`else
    lock_exp = '{2, 3, 2, 3};
`endif
    step(1, 0, 8'h00, 8'h00, 1);
    for (int b = 0; b < 4; b++) begin
      step(0, 1, 8'h0C, (b == 2) ? 8'h04 : 8'h00, 1);
      chk("lock_sel", 32'(out_sel), 32'(lock_exp[b]));
    end

    // Reset during a held, locked beat
    step(1, 0, 8'h00, 8'h00, 1);
    step(0, 1, 8'h04, 8'h00, 0);
    step(1, 1, 8'h04, 8'h00, 0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    step(0, 1, 8'hFF, 8'h00, 1);
    chk("midrst_sel", 32'(out_sel), 32'd0);

    // Random traffic
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
      step(($urandom % 64) == 0, ($urandom % 8) != 0,
           N'($urandom) & N'($urandom | $urandom),
           N'($urandom), ($urandom % 4) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
